// File: rtl/cmac_acc_pipe_pkg.sv
// Shared types and helpers for the complex multiply/accumulate pipe.
// Holds the mode enum, the default widths and the generic signed saturator.
package cmac_acc_pipe_pkg;

  typedef enum logic [1:0] {
    ModeMul  = 2'd0,
    ModeMac  = 2'd1,
    ModeAdd  = 2'd2,
    ModeRsvd = 2'd3
  } cmac_mode_e;

  localparam int unsigned DefDataWidth = 16;
  localparam int unsigned DefAccWidth  = 40;
  localparam int unsigned DefShiftW    = 5;
  localparam int unsigned DefProdWidth = 2 * DefDataWidth;
  localparam int unsigned DefSumWidth  = DefProdWidth + 1;

  // Widest value the saturator handles; every caller sign-extends into it.
  localparam int unsigned MaxW = 64;

  // Clamp v to the signed range of a w-bit value (w < MaxW); sat flags a clamp.
  function automatic logic signed [MaxW-1:0] sat_to_dw(input logic signed [MaxW-1:0] v,
                                                       input int unsigned w,
                                                       output logic sat);
    logic signed [MaxW-1:0] one, hi, lo, res;
    one = {{(MaxW-1){1'b0}}, 1'b1};
    hi  = (one << (w - 1)) - one;
    lo  = ~hi;
    sat = 1'b0;
    res = v;
    if (v > hi) begin
      res = hi;
      sat = 1'b1;
    end else if (v < lo) begin
      res = lo;
      sat = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/cmac_acc_pipe_if.sv
// Operation/result bundle of cmac_acc_pipe: the issuer drives the master side,
// the pipe sits on the slave side.
interface cmac_acc_pipe_if
  import cmac_acc_pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned SHIFT_W    = DefShiftW
);

  logic                    in_valid;
  cmac_mode_e              mode;
  logic                    acc_clr;
  logic [SHIFT_W-1:0]      shift;
  logic [2*DATA_WIDTH-1:0] opa;
  logic [2*DATA_WIDTH-1:0] opb;
  logic [2*DATA_WIDTH-1:0] opc;
  logic                    out_valid;
  logic [2*DATA_WIDTH-1:0] out_data;
  logic                    out_sat;
  logic                    acc_ovf;

  modport master (
    output in_valid, mode, acc_clr, shift, opa, opb, opc,
    input  out_valid, out_data, out_sat, acc_ovf
  );

  modport slave (
    input  in_valid, mode, acc_clr, shift, opa, opb, opc,
    output out_valid, out_data, out_sat, acc_ovf
  );

endinterface

// File: rtl/cmac_acc_pipe_shift_sat.sv
// Wide signed value -> arithmetic right shift -> saturate to DATA_WIDTH, with flag.
// Define CMAC_ROUND_EN to round half toward +inf instead of truncating.
module cmac_acc_pipe_shift_sat
  import cmac_acc_pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ACC_WIDTH  = DefAccWidth,
  parameter int unsigned SHIFT_W    = DefShiftW
) (
  input  logic signed [ACC_WIDTH-1:0] din,
  input  logic [SHIFT_W-1:0]          shift,
  output logic [DATA_WIDTH-1:0]       dout,
  output logic                        sat
);

  // One guard bit so the rounding increment cannot wrap the sign.
  localparam int unsigned ExtW = ACC_WIDTH + 1;

  logic signed [ExtW-1:0] ext;
  logic signed [ExtW-1:0] shifted;
`ifdef CMAC_ROUND_EN
  logic signed [ExtW-1:0] rnd;
`endif

  always_comb begin
    ext = {din[ACC_WIDTH-1], din};
`ifdef CMAC_ROUND_EN
    rnd = '0;
    if (shift != '0) begin
      rnd = {{(ExtW-1){1'b0}}, 1'b1} << (shift - 1'b1);
    end
    ext = ext + rnd;
`endif
    shifted = ext >>> shift;
    dout    = DATA_WIDTH'(sat_to_dw(MaxW'(shifted), DATA_WIDTH, sat));
  end

endmodule

// File: rtl/cmac_acc_pipe.sv
// 3-stage signed complex MUL / MAC / ADD pipe with wide accumulator and output saturation.
// Rounding on the output shift is selected by CMAC_ROUND_EN (see cmac_acc_pipe_shift_sat).
module cmac_acc_pipe
  import cmac_acc_pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ACC_WIDTH  = DefAccWidth,
  parameter int unsigned SHIFT_W    = DefShiftW
) (
  input logic           clk,
  input logic           rst_n,
  cmac_acc_pipe_if.slave bus
);

  localparam int unsigned ProdW = 2 * DATA_WIDTH;
  localparam int unsigned SumW  = ProdW + 1;
  localparam int unsigned AddW  = DATA_WIDTH + 1;

  logic signed [DATA_WIDTH-1:0] a_re, a_im, b_re, b_im, c_re, c_im;

  assign a_re = bus.opa[2*DATA_WIDTH-1:DATA_WIDTH];
  assign a_im = bus.opa[DATA_WIDTH-1:0];
  assign b_re = bus.opb[2*DATA_WIDTH-1:DATA_WIDTH];
  assign b_im = bus.opb[DATA_WIDTH-1:0];
  assign c_re = bus.opc[2*DATA_WIDTH-1:DATA_WIDTH];
  assign c_im = bus.opc[DATA_WIDTH-1:0];

  // Reserved mode is treated as a bubble from the very first stage.
  logic in_op;
  assign in_op = bus.in_valid && (bus.mode != ModeRsvd);

  // ---------------- Stage 1: partial products and ADD sums
  logic                    s1_valid_q;
  cmac_mode_e              s1_mode_q;
  logic                    s1_clr_q;
  logic [SHIFT_W-1:0]      s1_shift_q;
  logic signed [ProdW-1:0] s1_rr_q, s1_ii_q, s1_ri_q, s1_ir_q;
  logic signed [AddW-1:0]  s1_add_re_q, s1_add_im_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= ModeMul;
      s1_clr_q    <= 1'b0;
      s1_shift_q  <= '0;
      s1_rr_q     <= '0;
      s1_ii_q     <= '0;
      s1_ri_q     <= '0;
      s1_ir_q     <= '0;
      s1_add_re_q <= '0;
      s1_add_im_q <= '0;
    end else begin
      s1_valid_q  <= in_op;
      s1_mode_q   <= bus.mode;
      s1_clr_q    <= bus.acc_clr;
      s1_shift_q  <= bus.shift;
      s1_rr_q     <= ProdW'(a_re) * ProdW'(b_re);
      s1_ii_q     <= ProdW'(a_im) * ProdW'(b_im);
      s1_ri_q     <= ProdW'(a_re) * ProdW'(b_im);
      s1_ir_q     <= ProdW'(a_im) * ProdW'(b_re);
      s1_add_re_q <= AddW'(a_re) + AddW'(c_re);
      s1_add_im_q <= AddW'(a_im) + AddW'(c_im);
    end
  end

  // ---------------- Stage 2: complex combine and accumulate
  logic signed [SumW-1:0]      re, im;
  logic signed [ACC_WIDTH-1:0] acc_re_q, acc_im_q, acc_re_d, acc_im_d;
  logic signed [ACC_WIDTH-1:0] base_re, base_im;
  logic signed [ACC_WIDTH:0]   sum_re, sum_im;
  logic                        clamp_re, clamp_im;
  logic                        acc_ovf_q, acc_ovf_d;
  logic signed [ACC_WIDTH-1:0] s2_re_d, s2_im_d;
  logic [SHIFT_W-1:0]          s2_shift_d;

  always_comb begin
    re        = SumW'(s1_rr_q) - SumW'(s1_ii_q);
    im        = SumW'(s1_ri_q) + SumW'(s1_ir_q);
    base_re   = s1_clr_q ? '0 : acc_re_q;
    base_im   = s1_clr_q ? '0 : acc_im_q;
    sum_re    = (ACC_WIDTH + 1)'(base_re) + (ACC_WIDTH + 1)'(re);
    sum_im    = (ACC_WIDTH + 1)'(base_im) + (ACC_WIDTH + 1)'(im);
    clamp_re  = 1'b0;
    clamp_im  = 1'b0;
    acc_re_d  = acc_re_q;
    acc_im_d  = acc_im_q;
    acc_ovf_d = acc_ovf_q;
    if (s1_valid_q && (s1_mode_q == ModeMac)) begin
      acc_re_d  = ACC_WIDTH'(sat_to_dw(MaxW'(sum_re), ACC_WIDTH, clamp_re));
      acc_im_d  = ACC_WIDTH'(sat_to_dw(MaxW'(sum_im), ACC_WIDTH, clamp_im));
      acc_ovf_d = (acc_ovf_q & ~s1_clr_q) | clamp_re | clamp_im;
    end

    s2_shift_d = s1_shift_q;
    case (s1_mode_q)
      ModeMac: begin
        s2_re_d = acc_re_d;
        s2_im_d = acc_im_d;
      end
      ModeAdd: begin
        // ADD goes through the same saturator with no shift.
        s2_re_d    = ACC_WIDTH'(s1_add_re_q);
        s2_im_d    = ACC_WIDTH'(s1_add_im_q);
        s2_shift_d = '0;
      end
      default: begin
        s2_re_d = ACC_WIDTH'(re);
        s2_im_d = ACC_WIDTH'(im);
      end
    endcase
  end

  logic                        s2_valid_q;
  logic signed [ACC_WIDTH-1:0] s2_re_q, s2_im_q;
  logic [SHIFT_W-1:0]          s2_shift_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_re_q   <= '0;
      acc_im_q   <= '0;
      acc_ovf_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_re_q    <= '0;
      s2_im_q    <= '0;
      s2_shift_q <= '0;
    end else begin
      acc_re_q   <= acc_re_d;
      acc_im_q   <= acc_im_d;
      acc_ovf_q  <= acc_ovf_d;
      s2_valid_q <= s1_valid_q;
      s2_re_q    <= s2_re_d;
      s2_im_q    <= s2_im_d;
      s2_shift_q <= s2_shift_d;
    end
  end

  // ---------------- Stage 3: shift, saturate, register outputs
  logic [DATA_WIDTH-1:0] res_re, res_im;
  logic                  sat_re, sat_im;

  cmac_acc_pipe_shift_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .SHIFT_W    (SHIFT_W)
  ) u_shift_sat_re (
    .din   (s2_re_q),
    .shift (s2_shift_q),
    .dout  (res_re),
    .sat   (sat_re)
  );

  cmac_acc_pipe_shift_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .SHIFT_W    (SHIFT_W)
  ) u_shift_sat_im (
    .din   (s2_im_q),
    .shift (s2_shift_q),
    .dout  (res_im),
    .sat   (sat_im)
  );

  logic                    out_valid_q;
  logic [2*DATA_WIDTH-1:0] out_data_q;
  logic                    out_sat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        out_data_q <= {res_re, res_im};
        out_sat_q  <= sat_re | sat_im;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.acc_ovf   = acc_ovf_q;

endmodule

// File: tb/tb_cmac_acc_pipe.sv
// Scoreboard bench for cmac_acc_pipe: the driver queues expected results, the monitor
// pops and compares every out_valid beat (value, sat flag and 3-cycle latency).
module tb_cmac_acc_pipe;
  import cmac_acc_pipe_pkg::*;

  logic clk;
  logic rst_n;
  int   cyc;
  int   errors;
  int   checks;

  typedef struct {
    logic [31:0] data;
    logic        sat;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];

  cmac_acc_pipe_if #(.DATA_WIDTH(16), .SHIFT_W(5)) bus ();

  cmac_acc_pipe #(
    .DATA_WIDTH (16),
    .ACC_WIDTH  (40),
    .SHIFT_W    (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

`ifdef CMAC_ROUND_EN
  localparam logic [15:0] ShPosRe = 16'd6;
  localparam logic [15:0] ShPosIm = 16'd4;
  localparam logic [15:0] ShNegIm = 16'hFFFD;
`else
  localparam logic [15:0] ShPosRe = 16'd5;
  localparam logic [15:0] ShPosIm = 16'd3;
  localparam logic [15:0] ShNegIm = 16'hFFFC;
`endif

  // Monitor: every presented result must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got data=%h sat=%b at cycle %0d, required no output",
                 bus.out_data, bus.out_sat, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.out_data !== e.data || bus.out_sat !== e.sat || cyc != e.cyc) begin
          errors++;
          $display("FAIL result: got data=%h sat=%b cycle=%0d, required data=%h sat=%b cycle=%0d",
                   bus.out_data, bus.out_sat, cyc, e.data, e.sat, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic issue(input cmac_mode_e m, input logic clr, input logic [4:0] sh,
                       input logic [15:0] ar, input logic [15:0] ai,
                       input logic [15:0] br, input logic [15:0] bi,
                       input logic [15:0] cr, input logic [15:0] ci,
                       input logic [15:0] er, input logic [15:0] ei, input logic es,
                       input bit want);
    exp_t e;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.mode     = m;
    bus.acc_clr  = clr;
    bus.shift    = sh;
    bus.opa      = {ar, ai};
    bus.opb      = {br, bi};
    bus.opc      = {cr, ci};
    if (want) begin
      e.data = {er, ei};
      e.sat  = es;
      e.cyc  = cyc + 3;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.acc_clr  = 1'b0;
    bus.mode     = ModeMul;
  endtask

  task automatic drain();
    int n;
    idle();
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Reference for the long accumulate run: shift (optionally rounded), saturate to 16 bits.
  function automatic void model_out(input longint v, input int sh,
                                    output logic [15:0] d, output logic s);
    longint x;
    x = v;
`ifdef CMAC_ROUND_EN
    if (sh > 0) x = x + (longint'(1) << (sh - 1));
`endif
    x = x >>> sh;
    s = 1'b1;
    if (x > 32767) d = 16'h7FFF;
    else if (x < -32768) d = 16'h8000;
    else begin
      d = x[15:0];
      s = 1'b0;
    end
  endfunction

  // 260 MAC beats of a=(-32768,-32768) b=(-32768,32767): per-beat product
  // re = 2^31-32768, im = 32768, so the re accumulator clamps at beat 257.
  task automatic ovf_run();
    longint acc_re, acc_im;
    longint amax, amin;
    logic [15:0] er, ei;
    logic sr, si;
    amax   = (longint'(1) << 39) - 1;
    amin   = -(longint'(1) << 39);
    acc_re = 0;
    acc_im = 0;
    for (int k = 0; k < 260; k++) begin
      acc_re = acc_re + 64'sd2147450880;
      acc_im = acc_im + 64'sd32768;
      if (acc_re > amax) acc_re = amax;
      if (acc_re < amin) acc_re = amin;
      model_out(acc_re, 31, er, sr);
      model_out(acc_im, 31, ei, si);
      issue(ModeMac, k == 0, 5'd31, 16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 16'h0, 16'h0,
            er, ei, sr | si, 1'b1);
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    errors       = 0;
    checks       = 0;
    cyc          = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.mode     = ModeMul;
    bus.acc_clr  = 1'b0;
    bus.shift    = '0;
    bus.opa      = '0;
    bus.opb      = '0;
    bus.opc      = '0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_out_data", bus.out_data, 32'h0);
    chk("reset_out_sat", 32'(bus.out_sat), 32'd0);
    chk("reset_acc_ovf", 32'(bus.acc_ovf), 32'd0);
    rst_n = 1'b1;

    // Basic multiply and saturation corners
    issue(ModeMul, 1'b0, 5'd0, 16'd3, 16'd4, 16'd5, 16'hFFFE, 16'd0, 16'd0,
          16'd23, 16'd14, 1'b0, 1'b1);
    issue(ModeMul, 1'b0, 5'd0, 16'h7FFF, 16'h0, 16'h7FFF, 16'h0, 16'd0, 16'd0,
          16'h7FFF, 16'h0, 1'b1, 1'b1);
    issue(ModeMul, 1'b0, 5'd0, 16'h8000, 16'h0, 16'h7FFF, 16'h0, 16'd0, 16'd0,
          16'h8000, 16'h0, 1'b1, 1'b1);
    // Shift: (23,14) and (-23,-14) by 2
    issue(ModeMul, 1'b0, 5'd2, 16'd3, 16'd4, 16'd5, 16'hFFFE, 16'd0, 16'd0,
          ShPosRe, ShPosIm, 1'b0, 1'b1);
    issue(ModeMul, 1'b0, 5'd2, 16'hFFFD, 16'hFFFC, 16'd5, 16'hFFFE, 16'd0, 16'd0,
          16'hFFFA, ShNegIm, 1'b0, 1'b1);
    drain();

    // MAC run with a bubble between beats 2 and 3
    issue(ModeMac, 1'b1, 5'd0, 16'd1, 16'd1, 16'd2, 16'd0, 16'd0, 16'd0,
          16'd2, 16'd2, 1'b0, 1'b1);
    issue(ModeMac, 1'b0, 5'd0, 16'd1, 16'd1, 16'd2, 16'd0, 16'd0, 16'd0,
          16'd4, 16'd4, 1'b0, 1'b1);
    idle();
    issue(ModeMac, 1'b0, 5'd0, 16'd1, 16'd1, 16'd2, 16'd0, 16'd0, 16'd0,
          16'd6, 16'd6, 1'b0, 1'b1);
    issue(ModeMac, 1'b0, 5'd0, 16'd1, 16'd1, 16'd2, 16'd0, 16'd0, 16'd0,
          16'd8, 16'd8, 1'b0, 1'b1);
    // acc_clr outside MAC, NOP and ADD must leave the accumulator at (8,8)
    issue(ModeMul, 1'b1, 5'd0, 16'd3, 16'd4, 16'd5, 16'hFFFE, 16'd0, 16'd0,
          16'd23, 16'd14, 1'b0, 1'b1);
    issue(ModeRsvd, 1'b1, 5'd0, 16'd1, 16'd1, 16'd2, 16'd0, 16'd0, 16'd0,
          16'd0, 16'd0, 1'b0, 1'b0);
    issue(ModeAdd, 1'b0, 5'd3, 16'h7000, 16'd1, 16'd5, 16'd5, 16'h2000, 16'd2,
          16'h7FFF, 16'd3, 1'b1, 1'b1);
    issue(ModeMac, 1'b0, 5'd0, 16'd1, 16'd1, 16'd2, 16'd0, 16'd0, 16'd0,
          16'd10, 16'd10, 1'b0, 1'b1);
    drain();
    chk("acc_ovf_idle", 32'(bus.acc_ovf), 32'd0);

    // Accumulator clamp, then clear via acc_clr
    ovf_run();
    chk("acc_ovf_set", 32'(bus.acc_ovf), 32'd1);
    issue(ModeMac, 1'b1, 5'd0, 16'd1, 16'd1, 16'd2, 16'd0, 16'd0, 16'd0,
          16'd2, 16'd2, 1'b0, 1'b1);
    drain();
    chk("acc_ovf_clr", 32'(bus.acc_ovf), 32'd0);

    // Reset with three MACs in flight and a clamped accumulator
    ovf_run();
    chk("acc_ovf_set2", 32'(bus.acc_ovf), 32'd1);
    issue(ModeMac, 1'b0, 5'd0, 16'd1, 16'd1, 16'd2, 16'd0, 16'd0, 16'd0,
          16'd0, 16'd0, 1'b0, 1'b0);
    issue(ModeMac, 1'b0, 5'd0, 16'd1, 16'd1, 16'd2, 16'd0, 16'd0, 16'd0,
          16'd0, 16'd0, 1'b0, 1'b0);
    issue(ModeMac, 1'b0, 5'd0, 16'd1, 16'd1, 16'd2, 16'd0, 16'd0, 16'd0,
          16'd0, 16'd0, 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_acc_ovf", 32'(bus.acc_ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    end
    issue(ModeMac, 1'b0, 5'd0, 16'd1, 16'd1, 16'd2, 16'd0, 16'd0, 16'd0,
          16'd2, 16'd2, 1'b0, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
